// File: rtl/led_matrix_bcm.sv
// led_matrix_bcm: HUB75 scan driver with bit-angle modulation (BCM).
// Pixels are fetched from an external synchronous frame store one column at a time.
// Each row is shifted out DEPTH times, once per bit plane, and each plane is lit
// for BASE_ON << plane cycles, which gives 2^DEPTH intensity levels per colour.
// Optional feature: define LED_MATRIX_BRIGHT_EN to add a global brightness input
// bright[7:0] that shortens the OE-low part of every SHOW window.
module led_matrix_bcm #(
    parameter int COLS      = 32,
    parameter int SCAN_ROWS = 16,
    parameter int ROW_W     = 4,
    parameter int COL_W     = 5,
    parameter int DEPTH     = 4,
    parameter int SETTLE    = 8,
    parameter int BASE_ON   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    output logic [ROW_W-1:0]     pix_row,
    output logic [COL_W-1:0]     pix_col,
    input  logic [3*DEPTH-1:0]   pix_up_rgb,
    input  logic [3*DEPTH-1:0]   pix_dn_rgb,
`ifdef LED_MATRIX_BRIGHT_EN
    input  logic [7:0]           bright,
`endif
    output logic                 R0,
    output logic                 G0,
    output logic                 B0,
    output logic                 R1,
    output logic                 G1,
    output logic                 B1,
    output logic                 LED_CLK,
    output logic                 STB,
    output logic                 OE,
    output logic [ROW_W-1:0]     sel_ABCD,
    output logic                 frame_done
);

    localparam int PL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DL_W = $clog2(SETTLE + 1) + 1;
    // Wide enough to hold BASE_ON << (DEPTH-1) without truncation.
    localparam int ON_W = $clog2((BASE_ON << (DEPTH - 1)) + 1);

    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(SCAN_ROWS - 1);
    localparam logic [PL_W-1:0]  LAST_PLANE = PL_W'(DEPTH - 1);
    localparam logic [DL_W-1:0]  SETTLE_LD  = DL_W'(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_SHIFT1 = 3'd2,
        S_SHIFT2 = 3'd3,
        S_BLANK  = 3'd4,
        S_LATCH  = 3'd5,
        S_SHOW   = 3'd6
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [ROW_W-1:0] row_r, row_nxt_s;
    logic [COL_W-1:0] col_r, col_nxt_s;
    logic [PL_W-1:0]  plane_r, plane_nxt_s;
    logic [DL_W-1:0]  delay_r, delay_nxt_s;
    logic [ON_W-1:0]  on_cnt_r, on_cnt_nxt_s;
    logic [ON_W-1:0]  on_len_s;
    logic [5:0]       rgb_r, rgb_nxt_s;          // {R0,G0,B0,R1,G1,B1}
    logic [ROW_W-1:0] sel_r, sel_nxt_s;
    logic             led_clk_r, led_clk_nxt_s;
    logic             stb_r, stb_nxt_s;
    logic             oe_r, oe_nxt_s;
    logic             done_r, done_nxt_s;

`ifdef LED_MATRIX_BRIGHT_EN
    logic [ON_W-1:0]  oe_left_r, oe_left_nxt_s;
    logic [ON_W+7:0]  bright_prod_s;
    logic [ON_W-1:0]  bright_on_s;
`endif

    // Select bit p of each colour channel of a packed {R,G,B} pixel.
    function automatic logic [2:0] plane_bits(input logic [3*DEPTH-1:0] pix,
                                              input logic [PL_W-1:0]    p);
        logic [DEPTH-1:0] r_s;
        logic [DEPTH-1:0] g_s;
        logic [DEPTH-1:0] b_s;
        r_s = pix[2*DEPTH +: DEPTH];
        g_s = pix[DEPTH +: DEPTH];
        b_s = pix[0 +: DEPTH];
        return {r_s[p], g_s[p], b_s[p]};
    endfunction

    assign on_len_s = ON_W'(BASE_ON) << plane_r;

`ifdef LED_MATRIX_BRIGHT_EN
    // Scaled OE-low length for the current plane: (on_len * bright) >> 8.
    always_comb begin
        bright_prod_s = (ON_W+8)'(on_len_s) * (ON_W+8)'(bright);
        bright_on_s   = bright_prod_s[ON_W+7:8];
    end
`endif

    // Next-state and next-output logic for the scan sequencer.
    always_comb begin
        state_nxt_s   = state_r;
        row_nxt_s     = row_r;
        col_nxt_s     = col_r;
        plane_nxt_s   = plane_r;
        delay_nxt_s   = delay_r;
        on_cnt_nxt_s  = on_cnt_r;
        rgb_nxt_s     = rgb_r;
        sel_nxt_s     = sel_r;
        led_clk_nxt_s = led_clk_r;
        stb_nxt_s     = stb_r;
        oe_nxt_s      = oe_r;
        done_nxt_s    = 1'b0;
`ifdef LED_MATRIX_BRIGHT_EN
        oe_left_nxt_s = oe_left_r;
`endif
        case (state_r)
            S_IDLE: begin
                oe_nxt_s      = 1'b1;
                led_clk_nxt_s = 1'b0;
                if (enable) begin
                    state_nxt_s = S_READ;
                    row_nxt_s   = '0;
                    col_nxt_s   = '0;
                    plane_nxt_s = '0;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_READ: begin
                // Address is already on pix_row/pix_col; RAM answers next cycle.
                led_clk_nxt_s = 1'b0;
                state_nxt_s   = S_SHIFT1;
            end
            S_SHIFT1: begin
                rgb_nxt_s   = {plane_bits(pix_up_rgb, plane_r), plane_bits(pix_dn_rgb, plane_r)};
                state_nxt_s = S_SHIFT2;
            end
            S_SHIFT2: begin
                led_clk_nxt_s = 1'b1;
                if (col_r == LAST_COL) begin
                    col_nxt_s   = '0;
                    oe_nxt_s    = 1'b1;
                    delay_nxt_s = SETTLE_LD;
                    state_nxt_s = S_BLANK;
                end else begin
                    col_nxt_s   = col_r + COL_W'(1);
                    state_nxt_s = S_READ;
                end
            end
            S_BLANK: begin
                led_clk_nxt_s = 1'b0;
                if (delay_r == '0) begin
                    stb_nxt_s   = 1'b1;
                    sel_nxt_s   = row_r;
                    delay_nxt_s = SETTLE_LD;
                    state_nxt_s = S_LATCH;
                end else begin
                    delay_nxt_s = delay_r - DL_W'(1);
                end
            end
            S_LATCH: begin
                if (delay_r == '0) begin
                    stb_nxt_s    = 1'b0;
                    on_cnt_nxt_s = on_len_s - ON_W'(1);
                    state_nxt_s  = S_SHOW;
`ifdef LED_MATRIX_BRIGHT_EN
                    if (bright_on_s == '0) begin
                        oe_nxt_s      = 1'b1;
                        oe_left_nxt_s = '0;
                    end else begin
                        oe_nxt_s      = 1'b0;
                        oe_left_nxt_s = bright_on_s - ON_W'(1);
                    end
`else
                    oe_nxt_s     = 1'b0;
`endif
                end else begin
                    delay_nxt_s = delay_r - DL_W'(1);
                end
            end
            S_SHOW: begin
                if (on_cnt_r == '0) begin
                    oe_nxt_s = 1'b1;
                    if (plane_r != LAST_PLANE) begin
                        plane_nxt_s = plane_r + PL_W'(1);
                        state_nxt_s = S_READ;
                    end else begin
                        plane_nxt_s = '0;
                        if (row_r == LAST_ROW) begin
                            // Frame wraps here; enable decides whether another frame runs.
                            row_nxt_s   = '0;
                            done_nxt_s  = 1'b1;
                            state_nxt_s = enable ? S_READ : S_IDLE;
                        end else begin
                            row_nxt_s   = row_r + ROW_W'(1);
                            state_nxt_s = S_READ;
                        end
                    end
                end else begin
                    on_cnt_nxt_s = on_cnt_r - ON_W'(1);
`ifdef LED_MATRIX_BRIGHT_EN
                    if (oe_left_r == '0) begin
                        oe_nxt_s = 1'b1;
                    end else begin
                        oe_left_nxt_s = oe_left_r - ON_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                oe_nxt_s    = 1'b1;
            end
        endcase
    end

    // State and output registers; reset forces a dark, idle panel immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_IDLE;
            row_r     <= '0;
            col_r     <= '0;
            plane_r   <= '0;
            delay_r   <= '0;
            on_cnt_r  <= '0;
            rgb_r     <= 6'b000000;
            sel_r     <= '0;
            led_clk_r <= 1'b0;
            stb_r     <= 1'b0;
            oe_r      <= 1'b1;
            done_r    <= 1'b0;
`ifdef LED_MATRIX_BRIGHT_EN
            oe_left_r <= '0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            row_r     <= row_nxt_s;
            col_r     <= col_nxt_s;
            plane_r   <= plane_nxt_s;
            delay_r   <= delay_nxt_s;
            on_cnt_r  <= on_cnt_nxt_s;
            rgb_r     <= rgb_nxt_s;
            sel_r     <= sel_nxt_s;
            led_clk_r <= led_clk_nxt_s;
            stb_r     <= stb_nxt_s;
            oe_r      <= oe_nxt_s;
            done_r    <= done_nxt_s;
`ifdef LED_MATRIX_BRIGHT_EN
            oe_left_r <= oe_left_nxt_s;
`endif
        end
    end

    assign pix_row    = row_r;
    assign pix_col    = col_r;
    assign R0         = rgb_r[5];
    assign G0         = rgb_r[4];
    assign B0         = rgb_r[3];
    assign R1         = rgb_r[2];
    assign G1         = rgb_r[1];
    assign B1         = rgb_r[0];
    assign LED_CLK    = led_clk_r;
    assign STB        = stb_r;
    assign OE         = oe_r;
    assign sel_ABCD   = sel_r;
    assign frame_done = done_r;

endmodule

// File: tb/tb_led_matrix_bcm.sv
// tb_led_matrix_bcm: self-checking bench for led_matrix_bcm with a small panel
// (COLS=4, SETTLE=2, BASE_ON=4, DEPTH=4) and a synchronous frame-store model.
module tb_led_matrix_bcm;

    localparam int COLS      = 4;
    localparam int SCAN_ROWS = 16;
    localparam int ROW_W     = 4;
    localparam int COL_W     = 2;
    localparam int DEPTH     = 4;
    localparam int SETTLE    = 2;
    localparam int BASE_ON   = 4;
    localparam int PW        = 3 * DEPTH;
    localparam int CELLS     = SCAN_ROWS * COLS;
    localparam int NV        = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic [ROW_W-1:0] pix_row;
    logic [COL_W-1:0] pix_col;
    logic [PW-1:0]    pix_up_rgb = '0;
    logic [PW-1:0]    pix_dn_rgb = '0;
    logic             R0, G0, B0, R1, G1, B1;
    logic             LED_CLK, STB, OE, frame_done;
    logic [ROW_W-1:0] sel_ABCD;
`ifdef LED_MATRIX_BRIGHT_EN
    logic [7:0]       bright = 8'd128;
`endif

    int tests = 0;
    int fails = 0;
    int fd_cnt = 0;
    int oe_viol = 0;
    int cyc_cnt = 0;
    logic led_prev = 1'b0;
    logic [5:0] exp_q [$];

    logic [PW-1:0] up_mem [CELLS];
    logic [PW-1:0] dn_mem [CELLS];

    typedef struct packed {
        logic [PW-1:0]         up;
        logic [PW-1:0]         dn;
        logic [DEPTH-1:0][5:0] bits;   // expected {R0,G0,B0,R1,G1,B1} per plane
    } vec_t;
    vec_t vecs [NV];

    led_matrix_bcm #(
        .COLS(COLS), .SCAN_ROWS(SCAN_ROWS), .ROW_W(ROW_W), .COL_W(COL_W),
        .DEPTH(DEPTH), .SETTLE(SETTLE), .BASE_ON(BASE_ON)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .pix_row(pix_row), .pix_col(pix_col),
        .pix_up_rgb(pix_up_rgb), .pix_dn_rgb(pix_dn_rgb),
`ifdef LED_MATRIX_BRIGHT_EN
        .bright(bright),
`endif
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .LED_CLK(LED_CLK), .STB(STB), .OE(OE),
        .sel_ABCD(sel_ABCD), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous frame store: data appears one clock after the address.
    always @(posedge clk) begin
        pix_up_rgb <= up_mem[{pix_row, pix_col}];
        pix_dn_rgb <= dn_mem[{pix_row, pix_col}];
        cyc_cnt    <= cyc_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: scoreboard on LED_CLK rises, OE overlap watch, frame_done counting.
    always @(negedge clk) begin
        if (LED_CLK && !led_prev && exp_q.size() > 0)
            check("shift_bits", {R0, G0, B0, R1, G1, B1}, exp_q.pop_front());
        if (!OE && (LED_CLK || STB || (LED_CLK != led_prev)))
            oe_viol <= oe_viol + 1;
        if (!reset_n)
            fd_cnt <= 0;
        else if (frame_done)
            fd_cnt <= fd_cnt + 1;
        led_prev <= LED_CLK;
    end

    function automatic int exp_oe(input int p);
`ifdef LED_MATRIX_BRIGHT_EN
        return ((BASE_ON << p) * int'(bright)) >> 8;
`else
        return BASE_ON << p;
`endif
    endfunction

    task automatic set_vec(input int i, input logic [PW-1:0] up, input logic [PW-1:0] dn,
                           input logic [5:0] b0, input logic [5:0] b1,
                           input logic [5:0] b2, input logic [5:0] b3);
        vecs[i].up      = up;
        vecs[i].dn      = dn;
        vecs[i].bits[0] = b0;
        vecs[i].bits[1] = b1;
        vecs[i].bits[2] = b2;
        vecs[i].bits[3] = b3;
    endtask

    task automatic fill(input logic [PW-1:0] up, input logic [PW-1:0] dn);
        for (int i = 0; i < CELLS; i++) begin
            up_mem[i] = up;
            dn_mem[i] = dn;
        end
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits for the next STB rising edge, counting LED_CLK rises on the way.
    task automatic wait_stb_rise(output int rises);
        logic lp;
        logic sp;
        int   n;
        lp = LED_CLK;
        sp = STB;
        rises = 0;
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (LED_CLK && !lp) rises++;
            if (STB && !sp) return;
            lp = LED_CLK;
            sp = STB;
        end
        tests++;
        fails++;
        $display("FAIL stb_wait: no STB rise within %0d cycles", n);
    endtask

    // Called on the cycle STB rose; returns the number of cycles STB stayed high.
    task automatic stb_width(output int w);
        w = 1;
        do begin
            @(negedge clk);
            if (STB) w++;
        end while (STB && w < 100);
    endtask

    task automatic oe_low_len(output int n);
        n = 0;
        while (!OE && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_fd(input int target);
        int n;
        n = 0;
        while (fd_cnt < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        int w;
        int n;
        int bad;
        int stb_t [DEPTH+1];

        set_vec(0, 12'hFFF, 12'h000, 6'b111000, 6'b111000, 6'b111000, 6'b111000);
        set_vec(1, 12'h500, 12'h000, 6'b100000, 6'b000000, 6'b100000, 6'b000000);
        set_vec(2, 12'h0A0, 12'h00C, 6'b000000, 6'b010000, 6'b000001, 6'b010001);
        set_vec(3, 12'h000, 12'h963, 6'b000101, 6'b000011, 6'b000010, 6'b000100);
        set_vec(4, 12'h124, 12'h842, 6'b100000, 6'b010001, 6'b001010, 6'b000100);

        // Reset values while reset_n is held low.
        fill(12'h000, 12'h000);
        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_OE", OE, 1);
        check("rst_STB", STB, 0);
        check("rst_LED_CLK", LED_CLK, 0);
        check("rst_sel", sel_ABCD, 0);
        check("rst_pix_row", pix_row, 0);
        check("rst_pix_col", pix_col, 0);
        check("rst_data", {R0, G0, B0, R1, G1, B1}, 0);
        check("rst_frame_done", frame_done, 0);

        // Idle with enable low for 100 clocks: everything static and dark.
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (OE !== 1'b1 || STB !== 1'b0 || LED_CLK !== 1'b0 || sel_ABCD !== '0 ||
                {R0, G0, B0, R1, G1, B1} !== 6'b000000 || frame_done !== 1'b0 ||
                pix_row !== '0 || pix_col !== '0)
                bad++;
        end
        check("idle_static", bad, 0);

        // Table-driven pixel vectors: every shifted bit of row 0 goes through the scoreboard.
        for (int v = 0; v < NV; v++) begin
            do_reset();
            fill(vecs[v].up, vecs[v].dn);
            for (int p = 0; p < DEPTH; p++)
                for (int c = 0; c < COLS; c++)
                    exp_q.push_back(vecs[v].bits[p]);
            enable = 1'b1;
            n = 0;
            while (exp_q.size() > 0 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("shift_drain", exp_q.size(), 0);
            exp_q.delete();
        end

        // Plane timing: clock count, STB width, OE-low length and plane period.
        do_reset();
        fill(12'hFFF, 12'h000);
        enable = 1'b1;
        for (int p = 0; p <= DEPTH; p++) begin
            wait_stb_rise(rises);
            stb_t[p] = cyc_cnt;
            if (p < DEPTH) begin
                check("plane_clk_rises", rises, COLS);
                stb_width(w);
                check("stb_width", w, SETTLE + 1);
                oe_low_len(n);
                check("oe_low_len", n, exp_oe(p));
            end
        end
        for (int p = 0; p < DEPTH; p++)
            check("plane_period", stb_t[p+1] - stb_t[p],
                  3 * COLS + 2 * (SETTLE + 1) + (BASE_ON << p));

        // Full frame: sel_ABCD steps through every row, frame_done once, then wraps.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < SCAN_ROWS * DEPTH; i++) begin
            wait_stb_rise(rises);
            check("frame1_sel", sel_ABCD, i / DEPTH);
        end
        wait_fd(1);
        check("frame1_done", fd_cnt, 1);

        // Second frame: enable dropped during row 5, frame must still complete.
        for (int i = 0; i < SCAN_ROWS * DEPTH; i++) begin
            wait_stb_rise(rises);
            check("frame2_sel", sel_ABCD, i / DEPTH);
            if (i == 5 * DEPTH) enable = 1'b0;
        end
        wait_fd(2);
        check("frame2_done", fd_cnt, 2);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (LED_CLK !== 1'b0 || OE !== 1'b1 || STB !== 1'b0) bad++;
        end
        check("idle_after_frame", bad, 0);
        check("frame_done_total", fd_cnt, 2);
        check("row_wrapped", pix_row, 0);

        // Reset asserted during SHOW: outputs go dark without waiting for a clock.
        do_reset();
        enable = 1'b1;
        wait_stb_rise(rises);
        wait_stb_rise(rises);
        stb_width(w);
        check("show_oe_low", OE, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_OE", OE, 1);
        check("async_rst_STB", STB, 0);
        check("async_rst_pix_row", pix_row, 0);
        check("async_rst_sel", sel_ABCD, 0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_stb_rise(rises);
        check("restart_rises", rises, COLS);
        check("restart_sel", sel_ABCD, 0);
        stb_width(w);
        oe_low_len(n);
        check("restart_plane0_oe", n, exp_oe(0));
        enable = 1'b0;

        check("oe_overlap", oe_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
